// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display fetches take absolute priority and CPU accesses fill the
// free slots. A two-stage tag pipeline routes returned RAM data to the requester that issued it.
module vram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 64
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic        disp_req,
  input  logic [12:0] disp_addr,
  output logic [7:0]  disp_data,
  output logic        disp_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_starved,
  output logic        ram_en,
  output logic        ram_we,
  output logic [12:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] TagNone = 2'd0;
  localparam logic [1:0] TagDisp = 2'd1;
  localparam logic [1:0] TagCpu  = 2'd2;

  logic [1:0]  r_state;
  logic [1:0]  w_state_d;
  logic [1:0]  r_tag1;
  logic [1:0]  r_tag2;
  logic [1:0]  w_tag_d;
  logic        w_disp_grant;
  logic        w_cpu_grant;
  logic        r_cpu_wr;
  logic [7:0]  r_starve_cnt;
  logic [7:0]  w_starve_cnt_d;
  logic        w_starve_hit;

  logic        r_ram_en;
  logic        r_ram_we;
  logic [12:0] r_ram_addr;
  logic [7:0]  r_ram_wdata;
  logic [7:0]  r_disp_data;
  logic        r_disp_valid;
  logic        r_cpu_ack;
  logic [7:0]  r_cpu_rdata;
  logic        r_cpu_starved;

  // Display wins every slot it asks for; the CPU only gets a slot from IDLE.
  always_comb begin
    w_disp_grant = disp_req;
    w_cpu_grant  = ~disp_req & cpu_req & (r_state == StIdle);
    w_tag_d      = TagNone;
    if (w_disp_grant) begin
      w_tag_d = TagDisp;
    end else if (w_cpu_grant) begin
      w_tag_d = TagCpu;
    end
  end

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle:  if (w_cpu_grant) w_state_d = StBusy;
      StBusy:  if (r_tag2 == TagCpu) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Counts consecutive cycles an idle, requesting CPU loses its slot to display.
  always_comb begin
    w_starve_cnt_d = r_starve_cnt;
    if (!cpu_req || w_cpu_grant) begin
      w_starve_cnt_d = 8'd0;
    end else if (w_disp_grant && (r_state == StIdle) && (r_starve_cnt != 8'hFF)) begin
      w_starve_cnt_d = r_starve_cnt + 8'd1;
    end
    w_starve_hit = (32'(w_starve_cnt_d) >= STARVE_LIMIT);
  end

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      r_state       <= StIdle;
      r_tag1        <= TagNone;
      r_tag2        <= TagNone;
      r_cpu_wr      <= 1'b0;
      r_starve_cnt  <= 8'd0;
      r_cpu_starved <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_tag1       <= w_tag_d;
      r_tag2       <= r_tag1;
      r_starve_cnt <= w_starve_cnt_d;
      if (w_cpu_grant) begin
        r_cpu_wr <= cpu_we;
      end
      if (w_starve_hit) begin
        r_cpu_starved <= 1'b1;
      end
    end
  end

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= 13'd0;
      r_ram_wdata <= 8'd0;
    end else begin
      r_ram_en <= w_disp_grant | w_cpu_grant;
      r_ram_we <= w_cpu_grant & cpu_we;
      if (w_disp_grant) begin
        r_ram_addr <= disp_addr;
      end else if (w_cpu_grant) begin
        r_ram_addr  <= cpu_addr;
        r_ram_wdata <= cpu_wdata;
      end
    end
  end

  // RAM data for an access is valid while its tag sits in stage 2.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      r_disp_data  <= 8'd0;
      r_disp_valid <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_cpu_rdata  <= 8'd0;
    end else begin
      r_disp_valid <= (r_tag2 == TagDisp);
      r_cpu_ack    <= (r_tag2 == TagCpu);
      if (r_tag2 == TagDisp) begin
        r_disp_data <= ram_rdata;
      end
      if ((r_tag2 == TagCpu) && !r_cpu_wr) begin
        r_cpu_rdata <= ram_rdata;
      end
    end
  end

  assign ram_en      = r_ram_en;
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign disp_data   = r_disp_data;
  assign disp_valid  = r_disp_valid;
  assign cpu_ack     = r_cpu_ack;
  assign cpu_rdata   = r_cpu_rdata;
  assign cpu_starved = r_cpu_starved;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios against fixed expectations, then random traffic
// against an event-calendar reference model of the arbitration rules.
module tb_vram_arbiter;

  localparam int Limit = 8;

  logic        pixel_clock = 1'b0;
  logic        reset       = 1'b0;
  logic        disp_req    = 1'b0;
  logic [12:0] disp_addr   = 13'd0;
  logic        cpu_req     = 1'b0;
  logic        cpu_we      = 1'b0;
  logic [12:0] cpu_addr    = 13'd0;
  logic [7:0]  cpu_wdata   = 8'd0;
  logic [7:0]  ram_rdata   = 8'd0;
  logic [7:0]  disp_data;
  logic        disp_valid;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        cpu_starved;
  logic        ram_en;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 pixel_clock = ~pixel_clock;

  vram_arbiter #(.STARVE_LIMIT(Limit)) dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_data   (disp_data),
    .disp_valid  (disp_valid),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .cpu_starved (cpu_starved),
    .ram_en      (ram_en),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata)
  );

  // Synchronous single-port RAM
  logic [7:0] ram_mem [8192];
  always @(posedge pixel_clock) begin
    if (ram_en) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram_mem[ram_addr];
    end
  end

  // Reference model: grants applied to a memory image at grant time, results posted
  // to a calendar two cycles ahead.
  logic [7:0]  mdl_mem [8192];
  int          cyc = 0;
  int          cpu_free_at = 0;
  int          wait_run = 0;
  bit          mdl_starved = 1'b0;
  bit          dv_cal [4];
  logic [7:0]  dd_cal [4];
  bit          ack_cal [4];
  bit          ackrd_cal [4];
  logic [7:0]  ad_cal [4];
  bit          e_dv, e_ack, e_en, e_we, e_starved;
  logic [7:0]  e_dd, e_rdata, e_wdata;
  logic [12:0] e_addr;
  bit          rel_pend = 1'b0;

  function automatic void model_edge();
    bit cpu_free;
    int s;
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        dv_cal[i]  = 1'b0;
        ack_cal[i] = 1'b0;
      end
      e_dv = 0; e_ack = 0; e_en = 0; e_we = 0; e_starved = 0;
      e_dd = 0; e_rdata = 0; e_wdata = 0; e_addr = 0;
      wait_run = 0; mdl_starved = 0; cpu_free_at = cyc;
      return;
    end
    cyc++;
    s = cyc % 4;
    e_dv = dv_cal[s];
    if (e_dv) e_dd = dd_cal[s];
    dv_cal[s] = 1'b0;
    e_ack = ack_cal[s];
    if (e_ack && ackrd_cal[s]) e_rdata = ad_cal[s];
    ack_cal[s] = 1'b0;
    cpu_free = (cyc >= cpu_free_at);
    s = (cyc + 2) % 4;
    e_en = 1'b0;
    e_we = 1'b0;
    if (disp_req) begin
      e_en = 1'b1;
      e_addr = disp_addr;
      dv_cal[s] = 1'b1;
      dd_cal[s] = mdl_mem[disp_addr];
      if (cpu_req && cpu_free) wait_run++;
    end else if (cpu_req && cpu_free) begin
      e_en = 1'b1;
      e_we = cpu_we;
      e_addr = cpu_addr;
      e_wdata = cpu_wdata;
      ack_cal[s] = 1'b1;
      ackrd_cal[s] = !cpu_we;
      if (cpu_we) mdl_mem[cpu_addr] = cpu_wdata;
      else ad_cal[s] = mdl_mem[cpu_addr];
      cpu_free_at = cyc + 4;
      wait_run = 0;
    end
    if (!cpu_req) wait_run = 0;
    if (wait_run >= Limit) mdl_starved = 1'b1;
    e_starved = mdl_starved;
  endfunction

  // One clock: model evaluates the edge, outputs sampled 1 time unit later. The CPU
  // drops its request one cycle after seeing its ack.
  task automatic step();
    @(posedge pixel_clock);
    model_edge();
    #1;
    if (rel_pend) begin
      cpu_req  = 1'b0;
      rel_pend = 1'b0;
    end else if (e_ack) begin
      rel_pend = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({disp_valid, cpu_ack, cpu_starved, ram_en, ram_we, disp_data, cpu_rdata, ram_addr,
         ram_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got dv=%b ack=%b st=%b en=%b we=%b dd=%h rd=%h a=%h wd=%h, want all 0",
               disp_valid, cpu_ack, cpu_starved, ram_en, ram_we, disp_data, cpu_rdata, ram_addr,
               ram_wdata);
    end
    reset = 1'b1;
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0010;
    step();
    n_cmp++;
    if (ram_en !== 1'b1 || ram_addr !== 13'h0010) begin
      n_bad++;
      $display("FAIL reset_pre_grant: got en=%b addr=%h, want en=1 addr=0010", ram_en, ram_addr);
    end
    #2 reset = 1'b0;
    cpu_req = 1'b0;
    #1;
    n_cmp++;
    if ({ram_en, ram_we, ram_addr, cpu_ack, disp_valid} !== '0) begin
      n_bad++;
      $display("FAIL reset_async_clear: got en=%b we=%b addr=%h ack=%b dv=%b, want all 0",
               ram_en, ram_we, ram_addr, cpu_ack, disp_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (cpu_ack !== 1'b0 || disp_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_no_ack[%0d]: got ack=%b dv=%b, want 0 0", i, cpu_ack, disp_valid);
      end
    end
    reset = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0011;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (cpu_ack !== (i == 2) || (i == 2 && cpu_rdata !== 8'hA1)) begin
        n_bad++;
        $display("FAIL reset_after_read[%0d]: got ack=%b rdata=%h, want ack=%b rdata=a1",
                 i, cpu_ack, cpu_rdata, (i == 2));
      end
    end
  endtask

  task automatic test_display_only();
    bit exp_v;
    repeat (2) step();
    for (int j = 0; j < 8; j++) begin
      if (j < 4) begin
        disp_req = 1'b1;
        disp_addr = 13'(16 + j);
      end else begin
        disp_req = 1'b0;
      end
      step();
      exp_v = (j >= 2 && j <= 5);
      n_cmp++;
      if (disp_valid !== exp_v || (exp_v && disp_data !== 8'(160 + j - 2))) begin
        n_bad++;
        $display("FAIL disp_only[%0d]: got dv=%b data=%h, want dv=%b data=%h",
                 j, disp_valid, disp_data, exp_v, 8'(160 + j - 2));
      end
    end
  endtask

  task automatic test_cpu_write_read();
    repeat (2) step();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1FFF; cpu_wdata = 8'h5A;
    step();
    n_cmp++;
    if (ram_en !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 13'h1FFF || ram_wdata !== 8'h5A) begin
      n_bad++;
      $display("FAIL wr_grant: got en=%b we=%b a=%h wd=%h, want 1 1 1fff 5a",
               ram_en, ram_we, ram_addr, ram_wdata);
    end
    for (int i = 1; i < 4; i++) begin
      step();
      n_cmp++;
      if (cpu_ack !== (i == 2) || (i == 3 && ram_en !== 1'b0)) begin
        n_bad++;
        $display("FAIL wr_ack[%0d]: got ack=%b en=%b, want ack=%b en=0", i, cpu_ack, ram_en,
                 (i == 2));
      end
    end
    cpu_req = 1'b1; cpu_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (cpu_ack !== (i == 2) || (i == 0 && (ram_en !== 1'b1 || ram_we !== 1'b0)) ||
          (i == 2 && cpu_rdata !== 8'h5A)) begin
        n_bad++;
        $display("FAIL rd_back[%0d]: got ack=%b en=%b we=%b rdata=%h, want ack=%b rdata=5a",
                 i, cpu_ack, ram_en, ram_we, cpu_rdata, (i == 2));
      end
    end
  endtask

  task automatic test_collision();
    repeat (2) step();
    disp_req = 1'b1; disp_addr = 13'h0100;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0100; cpu_wdata = 8'h77;
    step();
    n_cmp++;
    if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 13'h0100) begin
      n_bad++;
      $display("FAIL coll_disp_first: got en=%b we=%b a=%h, want 1 0 0100", ram_en, ram_we,
               ram_addr);
    end
    disp_req = 1'b0;
    step();
    n_cmp++;
    if (ram_we !== 1'b1 || ram_addr !== 13'h0100 || ram_wdata !== 8'h77) begin
      n_bad++;
      $display("FAIL coll_cpu_next: got we=%b a=%h wd=%h, want 1 0100 77", ram_we, ram_addr,
               ram_wdata);
    end
    disp_req = 1'b1; disp_addr = 13'h0100;
    step();
    n_cmp++;
    if (disp_valid !== 1'b1 || disp_data !== 8'h00) begin
      n_bad++;
      $display("FAIL coll_old_data: got dv=%b data=%h, want 1 00", disp_valid, disp_data);
    end
    disp_req = 1'b0;
    step();
    n_cmp++;
    if (cpu_ack !== 1'b1) begin
      n_bad++;
      $display("FAIL coll_ack: got ack=%b, want 1", cpu_ack);
    end
    step();
    n_cmp++;
    if (disp_valid !== 1'b1 || disp_data !== 8'h77) begin
      n_bad++;
      $display("FAIL coll_new_data: got dv=%b data=%h, want 1 77", disp_valid, disp_data);
    end
  endtask

  task automatic test_interleave();
    repeat (2) step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h1FFF;
    step();
    disp_req = 1'b1; disp_addr = 13'h0012;
    step();
    disp_req = 1'b0;
    step();
    n_cmp++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h5A || disp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL ilv_ack: got ack=%b rdata=%h dv=%b, want 1 5a 0", cpu_ack, cpu_rdata,
               disp_valid);
    end
    step();
    n_cmp++;
    if (disp_valid !== 1'b1 || disp_data !== 8'hA2 || cpu_ack !== 1'b0) begin
      n_bad++;
      $display("FAIL ilv_disp: got dv=%b data=%h ack=%b, want 1 a2 0", disp_valid, disp_data,
               cpu_ack);
    end
  endtask

  task automatic test_starvation();
    repeat (2) step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0013;
    disp_req = 1'b1; disp_addr = 13'h0010;
    for (int e = 1; e <= 10; e++) begin
      step();
      n_cmp++;
      if (cpu_starved !== (e >= Limit) || ram_we !== 1'b0) begin
        n_bad++;
        $display("FAIL starve_wait[%0d]: got starved=%b we=%b, want starved=%b we=0",
                 e, cpu_starved, ram_we, (e >= Limit));
      end
    end
    disp_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (cpu_starved !== 1'b1 || cpu_ack !== (i == 2) || (i == 2 && cpu_rdata !== 8'hA3)) begin
        n_bad++;
        $display("FAIL starve_served[%0d]: got starved=%b ack=%b rdata=%h, want 1 %b a3",
                 i, cpu_starved, cpu_ack, cpu_rdata, (i == 2));
      end
    end
    reset = 1'b0;
    #1;
    n_cmp++;
    if (cpu_starved !== 1'b0) begin
      n_bad++;
      $display("FAIL starve_reset: got starved=%b, want 0", cpu_starved);
    end
    repeat (2) step();
    reset = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      disp_req  = ($urandom_range(0, 99) < 45);
      disp_addr = 13'($urandom_range(0, 31));
      if (!cpu_req && !rel_pend && $urandom_range(0, 3) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 13'($urandom_range(0, 31));
        cpu_wdata = 8'($urandom);
      end
      step();
      n_cmp++;
      if (disp_valid !== e_dv || disp_data !== e_dd || cpu_ack !== e_ack ||
          cpu_rdata !== e_rdata || cpu_starved !== e_starved || ram_en !== e_en ||
          ram_we !== e_we || ram_addr !== e_addr || ram_wdata !== e_wdata) begin
        n_bad++;
        $display("FAIL random[%0d]: got dv=%b dd=%h ack=%b rd=%h st=%b en=%b we=%b a=%h wd=%h; want dv=%b dd=%h ack=%b rd=%h st=%b en=%b we=%b a=%h wd=%h",
                 i, disp_valid, disp_data, cpu_ack, cpu_rdata, cpu_starved, ram_en, ram_we,
                 ram_addr, ram_wdata, e_dv, e_dd, e_ack, e_rdata, e_starved, e_en, e_we,
                 e_addr, e_wdata);
      end
    end
    disp_req = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) mdl_mem[a] = 8'($urandom);
    for (int a = 0; a < 4; a++) mdl_mem[16 + a] = 8'(160 + a);
    mdl_mem[256] = 8'h00;
    for (int a = 0; a < 8192; a++) ram_mem[a] <= mdl_mem[a];
    test_reset();
    test_display_only();
    test_cpu_write_read();
    test_collision();
    test_interleave();
    test_starvation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
